change_dispenser: RTL

Pays out customer change through two coin hoppers (100 and 500 units) after a sale or cancel. Takes a change amount, in 100-unit steps, from the coin-comparison logic. Drives one-coin eject pulses, largest denomination first, and reports the remaining amount for the seven-segment display. It is the outbound counterpart of the coin-accepting counter.

---
 rtl/coffee_pkg.sv | 29 ++
 rtl/dispense_timer.sv | 28 ++
 rtl/change_dispenser.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/coffee_pkg.sv
// Shared types and constants for the coin-handling blocks (counter, comparator,
// change dispenser). The dispenser state list depends on CHANGE_DISP_SENSE_EN:
// the sensed-payout states only exist when that macro is defined.
package coffee_pkg;

  localparam int AMOUNT_W = 4;

  localparam logic [AMOUNT_W-1:0] COIN_100_UNITS = 4'd1;
  localparam logic [AMOUNT_W-1:0] COIN_500_UNITS = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PULSE,
`ifdef CHANGE_DISP_SENSE_EN
    ST_WAIT_SENSE,
    ST_FAULT,
`endif
    ST_GAP,
    ST_FINISH
  } disp_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter shared by the pulse, gap and sense-wait phases.
// Load value N gives N+1 cycles until the zero flag is seen by the FSM.
module dispense_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount (in 100-unit steps) through the 500 and
// 100 hoppers, largest coin first, one registered eject pulse per coin.
// Optional macro CHANGE_DISP_SENSE_EN closes the loop on the coin-exit sensor
// (WAIT_SENSE with timeout into a sticky FAULT); without it payout is open-loop.
module change_dispenser
  import coffee_pkg::*;
#(
  parameter int PULSE_CYCLES  = 10_000_000,
  parameter int GAP_CYCLES    = 20_000_000,
  parameter int SENSE_TIMEOUT = 50_000_000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [AMOUNT_W-1:0] i_amount,
  input  logic                i_empty_500,
  input  logic                i_coin_sense,
  output logic                o_eject_100,
  output logic                o_eject_500,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_fault,
  output logic [AMOUNT_W-1:0] o_remaining
);

  localparam int TMR_MAX = max3(PULSE_CYCLES, GAP_CYCLES, SENSE_TIMEOUT);
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);

  disp_state_t         r_state, w_state_nxt;
  logic [AMOUNT_W-1:0] r_remaining, w_rem_nxt;
  logic                r_eject_100, w_e100_nxt;
  logic                r_eject_500, w_e500_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_coin_500, w_coin_500_nxt;
  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_val;
  logic                w_tmr_zero;
  logic [AMOUNT_W-1:0] w_coin_units;

  assign w_coin_units = r_coin_500 ? COIN_500_UNITS : COIN_100_UNITS;

  dispense_timer #(.W(TMR_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

`ifdef CHANGE_DISP_SENSE_EN
  localparam logic [TMR_W-1:0] SENSE_LOAD = TMR_W'(SENSE_TIMEOUT - 1);
  logic r_fault, w_fault_nxt;
  logic r_sense_d;
  logic w_sense_edge;

  assign w_sense_edge = i_coin_sense & ~r_sense_d;

  // Sensor history for rising-edge detection; a stuck-high sensor never counts.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sense_d <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_sense_d <= i_coin_sense;
      r_fault   <= w_fault_nxt;
    end
  end

  assign o_fault = r_fault;
`else
  logic w_unused_sense;
  assign w_unused_sense = i_coin_sense;
  assign o_fault = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt    = r_state;
    w_rem_nxt      = r_remaining;
    w_e100_nxt     = r_eject_100;
    w_e500_nxt     = r_eject_500;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_coin_500_nxt = r_coin_500;
    w_tmr_load     = 1'b0;
    w_tmr_val      = '0;
`ifdef CHANGE_DISP_SENSE_EN
    w_fault_nxt    = r_fault;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_rem_nxt   = i_amount;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if ((r_remaining >= COIN_500_UNITS) && !i_empty_500) begin
          w_coin_500_nxt = 1'b1;
          w_e500_nxt     = 1'b1;
          w_tmr_load     = 1'b1;
          w_tmr_val      = PULSE_LOAD;
          w_state_nxt    = ST_PULSE;
        end else if (r_remaining >= COIN_100_UNITS) begin
          w_coin_500_nxt = 1'b0;
          w_e100_nxt     = 1'b1;
          w_tmr_load     = 1'b1;
          w_tmr_val      = PULSE_LOAD;
          w_state_nxt    = ST_PULSE;
        end else begin
          w_done_nxt  = 1'b1;
          w_rem_nxt   = '0;
          w_state_nxt = ST_FINISH;
        end
      end
      ST_PULSE: begin
        if (w_tmr_zero) begin
          w_e100_nxt = 1'b0;
          w_e500_nxt = 1'b0;
          w_tmr_load = 1'b1;
`ifdef CHANGE_DISP_SENSE_EN
          w_tmr_val   = SENSE_LOAD;
          w_state_nxt = ST_WAIT_SENSE;
`else
          w_rem_nxt   = r_remaining - w_coin_units;
          w_tmr_val   = GAP_LOAD;
          w_state_nxt = ST_GAP;
`endif
        end
      end
`ifdef CHANGE_DISP_SENSE_EN
      ST_WAIT_SENSE: begin
        if (w_sense_edge) begin
          w_rem_nxt   = r_remaining - w_coin_units;
          w_tmr_load  = 1'b1;
          w_tmr_val   = GAP_LOAD;
          w_state_nxt = ST_GAP;
        end else if (w_tmr_zero) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
`endif
      ST_GAP: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_SELECT;
        end
      end
      ST_FINISH: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any payout in progress.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_eject_100 <= 1'b0;
      r_eject_500 <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_coin_500  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      r_eject_100 <= w_e100_nxt;
      r_eject_500 <= w_e500_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_coin_500  <= w_coin_500_nxt;
    end
  end

  assign o_eject_100 = r_eject_100;
  assign o_eject_500 = r_eject_500;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_remaining = r_remaining;

endmodule
